// File: rtl/regfile_writeback.sv
// Writeback arbiter/queue merging ALU and load results into one register-file write port.
// Optional forwarding lookup into queued/in-flight writes is enabled by defining WB_FORWARD_EN.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
`ifdef WB_FORWARD_EN
  input  logic [4:0]  fwd_rr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
`endif
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_wd,
  output logic        rf_regwrite,
  output logic [31:0] pending
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {GRANT_MEM = 1'b0, GRANT_ALU = 1'b1} grant_e;

  // Entry 0 is the head (oldest); entries at index >= count_q are don't-care.
  logic [4:0]    ent_rd_q   [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [4:0]    ent_rd_d   [DEPTH];
  logic [31:0]   ent_data_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  grant_e        grant_q, grant_d;

  logic [4:0]    rf_wr_q, rf_wr_d;
  logic [31:0]   rf_wd_q, rf_wd_d;
  logic          rf_regwrite_q, rf_regwrite_d;
  logic [31:0]   pending_q, pending_d;

  logic [CW-1:0] free;
  logic          alu_fire, mem_fire;

  assign free = CW'(DEPTH) - count_q;

  // Readies look only at registered occupancy, so a same-cycle pop never earns extra credit.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (free >= CW'(2)) begin
      alu_ready = 1'b1;
      mem_ready = 1'b1;
    end else if (free == CW'(1)) begin
      alu_ready = (grant_q == GRANT_ALU);
      mem_ready = (grant_q == GRANT_MEM);
    end
  end

  assign alu_fire = alu_valid && alu_ready && !rst;
  assign mem_fire = mem_valid && mem_ready && !rst;

  always_comb begin
    ent_rd_d      = ent_rd_q;
    ent_data_d    = ent_data_q;
    count_d       = count_q;
    grant_d       = grant_q;
    rf_wr_d       = rf_wr_q;
    rf_wd_d       = rf_wd_q;
    rf_regwrite_d = 1'b0;
    pending_d     = '0;

    if (count_q != '0) begin
      rf_wr_d       = ent_rd_q[0];
      rf_wd_d       = ent_data_q[0];
      rf_regwrite_d = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) begin
        ent_rd_d[i]   = ent_rd_q[i+1];
        ent_data_d[i] = ent_data_q[i+1];
      end
      count_d = count_q - CW'(1);
    end

    // The load result is the older of a simultaneous pair, so it is appended first.
    if (mem_fire && mem_rd != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count_d) begin
          ent_rd_d[i]   = mem_rd;
          ent_data_d[i] = mem_data;
        end
      end
      count_d = count_d + CW'(1);
    end

    if (alu_fire && alu_rd != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count_d) begin
          ent_rd_d[i]   = alu_rd;
          ent_data_d[i] = alu_data;
        end
      end
      count_d = count_d + CW'(1);
    end

    if (free == CW'(1)) begin
      if ((grant_q == GRANT_ALU && alu_fire) || (grant_q == GRANT_MEM && mem_fire)) begin
        grant_d = (grant_q == GRANT_ALU) ? GRANT_MEM : GRANT_ALU;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_d) begin
        pending_d[ent_rd_d[i]] = 1'b1;
      end
    end
    if (rf_regwrite_d) begin
      pending_d[rf_wr_d] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Queue payload is not reset; only entries below count_q are ever observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      grant_q       <= GRANT_MEM;
      rf_wr_q       <= '0;
      rf_wd_q       <= '0;
      rf_regwrite_q <= 1'b0;
      pending_q     <= '0;
    end else begin
      count_q       <= count_d;
      grant_q       <= grant_d;
      rf_wr_q       <= rf_wr_d;
      rf_wd_q       <= rf_wd_d;
      rf_regwrite_q <= rf_regwrite_d;
      pending_q     <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_rd_q   <= ent_rd_d;
    ent_data_q <= ent_data_d;
  end

  assign rf_wr       = rf_wr_q;
  assign rf_wd       = rf_wd_q;
  assign rf_regwrite = rf_regwrite_q;
  assign pending     = pending_q;

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rr != 5'd0) begin
      if (rf_regwrite_q && rf_wr_q == fwd_rr) begin
        fwd_hit  = 1'b1;
        fwd_data = rf_wd_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < count_q && ent_rd_q[i] == fwd_rr) begin
          fwd_hit  = 1'b1;
          fwd_data = ent_data_q[i];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a queue model predicts readies, rf port and pending.
// Define WB_FORWARD_EN to also exercise the forwarding lookup.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd = '0, mem_rd = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic        rf_regwrite;
  logic [31:0] pending;
`ifdef WB_FORWARD_EN
  logic [4:0]  fwd_rr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t sbq[$];
  ent_t mPort;
  bit   mPortV;
  bit   mGrantAlu;
  int   compared = 0;
  int   mismatched = 0;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
`ifdef WB_FORWARD_EN
    .fwd_rr(fwd_rr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .rf_wr(rf_wr), .rf_wd(rf_wd), .rf_regwrite(rf_regwrite), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic void expReady(output bit em, output bit ea);
    int free = DEPTH - sbq.size();
    em = (free >= 2) || (free == 1 && !mGrantAlu);
    ea = (free >= 2) || (free == 1 && mGrantAlu);
  endfunction

  function automatic logic [31:0] expPending();
    logic [31:0] p = '0;
    foreach (sbq[i]) p[sbq[i].rd] = 1'b1;
    if (mPortV) p[mPort.rd] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // Advance one clock from a negedge to the next, updating the model with what was accepted.
  task automatic tick();
    bit em, ea, mf, af;
    int free;
    expReady(em, ea);
    free = DEPTH - sbq.size();
    @(posedge clk);
    if (rst) begin
      sbq.delete();
      mPort = '0;
      mPortV = 1'b0;
      mGrantAlu = 1'b0;
    end else begin
      mf = mem_valid && em;
      af = alu_valid && ea;
      mPortV = (sbq.size() > 0);
      if (mPortV) mPort = sbq.pop_front();
      if (mf && mem_rd != 5'd0) sbq.push_back(ent_t'{rd: mem_rd, data: mem_data});
      if (af && alu_rd != 5'd0) sbq.push_back(ent_t'{rd: alu_rd, data: alu_data});
      if (free == 1 && (mGrantAlu ? af : mf)) mGrantAlu = !mGrantAlu;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    compared++; if (rf_regwrite !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_regwrite: got %0b want 0", rf_regwrite); end
    compared++; if (rf_wr !== 5'd0 || rf_wd !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_port: got rd=%0d wd=%h want 0/0", rf_wr, rf_wd); end
    compared++; if (pending !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_pending: got %h want 0", pending); end
    compared++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got alu=%0b mem=%0b want 1/1", alu_ready, mem_ready); end
`ifdef WB_FORWARD_EN
    fwd_rr = 5'd7;
    #1;
    compared++; if (fwd_hit !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fwd_hit: got %0b want 0", fwd_hit); end
    fwd_rr = 5'd0;
`endif
  endtask

  task automatic test_single();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
    tick();
    alu_valid = 1'b0;
    compared++; if (rf_regwrite !== 1'b0) begin mismatched++; $display("[TB] FAIL single_c1_regwrite: got %0b want 0", rf_regwrite); end
    compared++; if (pending !== 32'h20) begin mismatched++; $display("[TB] FAIL single_c1_pending: got %h want 00000020", pending); end
    tick();
    compared++; if (rf_regwrite !== 1'b1 || rf_wr !== 5'd5 || rf_wd !== 32'h11) begin mismatched++; $display("[TB] FAIL single_c2_port: got we=%0b rd=%0d wd=%h want 1/5/11", rf_regwrite, rf_wr, rf_wd); end
    compared++; if (pending !== 32'h20) begin mismatched++; $display("[TB] FAIL single_c2_pending: got %h want 00000020", pending); end
    tick();
    compared++; if (rf_regwrite !== 1'b0 || rf_wr !== 5'd5 || rf_wd !== 32'h11) begin mismatched++; $display("[TB] FAIL single_c3_hold: got we=%0b rd=%0d wd=%h want 0/5/11", rf_regwrite, rf_wr, rf_wd); end
    compared++; if (pending !== 32'd0) begin mismatched++; $display("[TB] FAIL single_c3_pending: got %h want 0", pending); end
  endtask

  task automatic test_both_order();
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hA;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hB;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    compared++; if (rf_regwrite !== 1'b0) begin mismatched++; $display("[TB] FAIL both_c1_regwrite: got %0b want 0", rf_regwrite); end
    tick();
    compared++; if (rf_regwrite !== 1'b1 || rf_wr !== 5'd3 || rf_wd !== 32'hA) begin mismatched++; $display("[TB] FAIL both_first: got we=%0b rd=%0d wd=%h want 1/3/a", rf_regwrite, rf_wr, rf_wd); end
    tick();
    compared++; if (rf_regwrite !== 1'b1 || rf_wr !== 5'd4 || rf_wd !== 32'hB) begin mismatched++; $display("[TB] FAIL both_second: got we=%0b rd=%0d wd=%h want 1/4/b", rf_regwrite, rf_wr, rf_wd); end
    tick();
    compared++; if (rf_regwrite !== 1'b0) begin mismatched++; $display("[TB] FAIL both_done: got %0b want 0", rf_regwrite); end
  endtask

  task automatic test_back_to_back();
    bit em, ea, haveSingle, lastSingleAlu;
    int mi = 0, ai = 0;
    haveSingle = 1'b0;
    lastSingleAlu = 1'b0;
    for (int c = 0; c < 16; c++) begin
      bit drive = (c < 10);
      expReady(em, ea);
      compared++; if (mem_ready !== em || alu_ready !== ea) begin mismatched++; $display("[TB] FAIL b2b_ready c%0d: got mem=%0b alu=%0b want mem=%0b alu=%0b", c, mem_ready, alu_ready, em, ea); end
      if (drive && (mem_ready ^ alu_ready)) begin
        if (haveSingle) begin
          compared++; if (alu_ready === lastSingleAlu) begin mismatched++; $display("[TB] FAIL b2b_alternate c%0d: got alu_ready=%0b want %0b", c, alu_ready, !lastSingleAlu); end
        end
        haveSingle = 1'b1;
        lastSingleAlu = alu_ready;
      end
      compared++; if (rf_regwrite !== mPortV || rf_wr !== mPort.rd || rf_wd !== mPort.data) begin mismatched++; $display("[TB] FAIL b2b_port c%0d: got we=%0b rd=%0d wd=%h want we=%0b rd=%0d wd=%h", c, rf_regwrite, rf_wr, rf_wd, mPortV, mPort.rd, mPort.data); end
      compared++; if (pending !== expPending()) begin mismatched++; $display("[TB] FAIL b2b_pending c%0d: got %h want %h", c, pending, expPending()); end
      mem_valid = drive; mem_rd = 5'(1 + 2 * mi); mem_data = 32'h100 + 32'(mi);
      alu_valid = drive; alu_rd = 5'(2 + 2 * ai); alu_data = 32'h200 + 32'(ai);
      tick();
      if (drive && em) mi++;
      if (drive && ea) ai++;
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    compared++; if (mi + ai < 12) begin mismatched++; $display("[TB] FAIL b2b_accepted: got %0d want >=12", mi + ai); end
  endtask

  task automatic test_rd_zero();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    compared++; if (alu_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rd0_ready: got %0b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      compared++; if (rf_regwrite !== 1'b0 || pending !== 32'd0) begin mismatched++; $display("[TB] FAIL rd0_quiet c%0d: got we=%0b pend=%h want 0/0", c, rf_regwrite, pending); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      mem_valid = 1'b1; mem_rd = 5'(9 + 2 * c); mem_data = 32'hC0 + 32'(c);
      alu_valid = 1'b1; alu_rd = 5'(10 + 2 * c); alu_data = 32'hD0 + 32'(c);
      tick();
      compared++; if (rf_regwrite !== mPortV || rf_wr !== mPort.rd || rf_wd !== mPort.data) begin mismatched++; $display("[TB] FAIL rstmid_fill c%0d: got we=%0b rd=%0d wd=%h want we=%0b rd=%0d wd=%h", c, rf_regwrite, rf_wr, rf_wd, mPortV, mPort.rd, mPort.data); end
    end
    compared++; if (pending !== expPending()) begin mismatched++; $display("[TB] FAIL rstmid_full_pending: got %h want %h", pending, expPending()); end
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
    compared++; if (rf_regwrite !== 1'b0 || rf_wr !== 5'd0 || rf_wd !== 32'd0) begin mismatched++; $display("[TB] FAIL rstmid_port: got we=%0b rd=%0d wd=%h want 0/0/0", rf_regwrite, rf_wr, rf_wd); end
    compared++; if (pending !== 32'd0) begin mismatched++; $display("[TB] FAIL rstmid_pending: got %h want 0", pending); end
    compared++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_ready: got alu=%0b mem=%0b want 1/1", alu_ready, mem_ready); end
    for (int c = 0; c < 4; c++) begin
      tick();
      compared++; if (rf_regwrite !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_flushed c%0d: got we=%0b rd=%0d want 0", c, rf_regwrite, rf_wr); end
    end
  endtask

`ifdef WB_FORWARD_EN
  task automatic test_forward();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h2;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    fwd_rr = 5'd7;
    #1;
    compared++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h2) begin mismatched++; $display("[TB] FAIL fwd_queued: got hit=%0b data=%h want 1/2", fwd_hit, fwd_data); end
    fwd_rr = 5'd0;
    #1;
    compared++; if (fwd_hit !== 1'b0) begin mismatched++; $display("[TB] FAIL fwd_r0: got %0b want 0", fwd_hit); end
    fwd_rr = 5'd7;
    tick();
    compared++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h2) begin mismatched++; $display("[TB] FAIL fwd_mixed: got hit=%0b data=%h want 1/2", fwd_hit, fwd_data); end
    tick();
    compared++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h2) begin mismatched++; $display("[TB] FAIL fwd_port: got hit=%0b data=%h want 1/2", fwd_hit, fwd_data); end
    tick();
    compared++; if (fwd_hit !== 1'b0) begin mismatched++; $display("[TB] FAIL fwd_drained: got %0b want 0", fwd_hit); end
    fwd_rr = 5'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_both_order();
    test_back_to_back();
    test_rd_zero();
    test_reset_mid();
`ifdef WB_FORWARD_EN
    test_forward();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
